poly_coef_unpacker: RTL and testbench

- Sits directly downstream of the BRAM polynomial load controller, on the BRAM read-data port.
- Consumes 52 packed 64-bit words holding one SABER polynomial (256 x 13-bit coefficients, 3328 bits, no padding).
- Emits the coefficients one per beat, in order, to the polynomial multiplier's coefficient loader.
- Uses a bit-accumulating buffer with valid/ready on both sides; pulses done after coefficient 255.

---
 rtl/poly_coef_unpacker_pkg.sv | 15 +
 rtl/poly_coef_unpacker_if.sv | 35 +++
 rtl/poly_bit_accum.sv | 48 ++++
 rtl/poly_coef_unpacker.sv | 113 +++++++++++
 tb/tb_poly_coef_unpacker.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_coef_unpacker_pkg.sv
// Shared constants and FSM encoding for the SABER polynomial coefficient unpacker.
package poly_coef_unpacker_pkg;
    localparam int WORD_W     = 64;
    localparam int COEF_W     = 13;
    localparam int N_COEFS    = 256;
    localparam int BUF_W      = WORD_W + COEF_W - 1;
    localparam int CNT_W      = 7;
    localparam int COEF_IDX_W = $clog2(N_COEFS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/poly_coef_unpacker_if.sv
// Handshake bundle between load controller, unpacker and coefficient loader.
// The err signal exists only when POLY_UNPACK_CHECK_EN is defined.
interface poly_coef_unpacker_if;
    import poly_coef_unpacker_pkg::*;

    logic                  start;
    logic [WORD_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [COEF_W-1:0]     coef_out;
    logic                  coef_valid;
    logic                  coef_ready;
    logic [COEF_IDX_W-1:0] coef_idx;
    logic                  busy;
    logic                  done;
`ifdef POLY_UNPACK_CHECK_EN
    logic                  err;
`endif

    modport slave (
        input  start, in_data, in_valid, coef_ready,
        output in_ready, coef_out, coef_valid, coef_idx, busy, done
`ifdef POLY_UNPACK_CHECK_EN
        , output err
`endif
    );

    modport master (
        output start, in_data, in_valid, coef_ready,
        input  in_ready, coef_out, coef_valid, coef_idx, busy, done
`ifdef POLY_UNPACK_CHECK_EN
        , input err
`endif
    );
endinterface

// File: rtl/poly_bit_accum.sv
// Bit-accumulating buffer: words are appended at the fill level, coefficients
// are taken from the bottom and the buffer shifts down.
module poly_bit_accum
    import poly_coef_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [COEF_W-1:0] coef_o,
    output logic [CNT_W-1:0]  cnt_o
);
    localparam logic [BUF_W-1:0] WMASK = {{(BUF_W-WORD_W){1'b0}}, {WORD_W{1'b1}}};

    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            // push only happens with cnt < COEF_W, so the word always fits
            acc_d = (acc_q & ~(WMASK << cnt_q)) | (BUF_W'(data_i) << cnt_q);
            cnt_d = cnt_q + CNT_W'(WORD_W);
        end else if (pop_i) begin
            acc_d = acc_q >> COEF_W;
            cnt_d = cnt_q - CNT_W'(COEF_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign coef_o = acc_q[COEF_W-1:0];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/poly_coef_unpacker.sv
// Unpacks 52 x 64-bit BRAM words into 256 x 13-bit SABER coefficients.
// Define POLY_UNPACK_CHECK_EN to add the sticky upstream-protocol err output.
module poly_coef_unpacker
    import poly_coef_unpacker_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    poly_coef_unpacker_if.slave bus
);
    state_e                state_q, state_d;
    logic [COEF_IDX_W-1:0] idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  clr;
    logic [CNT_W-1:0]      cnt;
    logic [COEF_W-1:0]     coef;
    logic                  in_rdy, c_vld, push, pop;

    assign in_rdy = (state_q == ST_RUN) && (cnt <  CNT_W'(COEF_W));
    assign c_vld  = (state_q == ST_RUN) && (cnt >= CNT_W'(COEF_W));
    assign push   = in_rdy && bus.in_valid;
    assign pop    = c_vld && bus.coef_ready;

    poly_bit_accum u_accum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .push_i (push),
        .data_i (bus.in_data),
        .pop_i  (pop),
        .coef_o (coef),
        .cnt_o  (cnt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (pop) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == COEF_IDX_W'(N_COEFS-1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.coef_valid = c_vld;
    assign bus.coef_out   = coef;
    assign bus.coef_idx   = idx_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = done_q;

`ifdef POLY_UNPACK_CHECK_EN
    logic              err_q, err_d;
    logic              hold_q;
    logic [WORD_W-1:0] data_q;
    logic              stalled;

    // A word only has to be held once it has been presented and refused;
    // the cycle after an accept legitimately carries the next word.
    assign stalled = (state_q == ST_RUN) && bus.in_valid && !in_rdy;

    always_comb begin
        err_d = err_q;
        if (bus.start)
            err_d = 1'b0;
        else if ((hold_q && stalled && (bus.in_data != data_q)) ||
                 ((state_q == ST_DONE) && (cnt != '0)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            hold_q <= 1'b0;
            data_q <= '0;
        end else begin
            err_q  <= err_d;
            hold_q <= stalled;
            data_q <= bus.in_data;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_poly_coef_unpacker.sv
// Scoreboard bench for poly_coef_unpacker: directed polynomials, stalls, reset and ignore cases.
module tb_poly_coef_unpacker;
    import poly_coef_unpacker_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_coef_unpacker_if bus();

    poly_coef_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          idx;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   done_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every coefficient handshake
    initial begin
        logic        prev_stall;
        logic [12:0] prev_c;
        logic [7:0]  prev_i;
        exp_t        e;
        prev_stall = 1'b0;
        prev_c = '0;
        prev_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.coef_valid || bus.in_ready)
                    chk("in_ready_vs_coef_valid", 64'(bus.coef_valid & bus.in_ready), 64'd0);
                if (prev_stall && bus.coef_valid) begin
                    chk("stall_coef_out", 64'(bus.coef_out), 64'(prev_c));
                    chk("stall_coef_idx", 64'(bus.coef_idx), 64'(prev_i));
                end
                if (bus.coef_valid && bus.coef_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_coef: got idx %0d val %0h want none",
                                 bus.coef_idx, bus.coef_out);
                    end else begin
                        e = sb.pop_front();
                        chk("coef_val", 64'(bus.coef_out), 64'(e.val));
                        chk("coef_idx", 64'(bus.coef_idx), 64'(e.idx));
                    end
                end
                if (bus.done) done_cnt++;
                prev_stall = bus.coef_valid && !bus.coef_ready;
                prev_c = bus.coef_out;
                prev_i = bus.coef_idx;
            end
        end
    end

    task automatic run_poly(input logic [3327:0] vec, input int pct, input int abort_n,
                            input int restart_at, output int busy_n);
        int k, npop, cyc;
        bit fin, fi, fp;
        k = 0; npop = 0; cyc = 0; fin = 0; busy_n = 0;
        @(posedge clk); #1;
        while (!fin && cyc < 4000) begin
            bus.start      = (cyc == 0) || (cyc == restart_at);
            bus.in_valid   = (k < 52);
            bus.in_data    = vec[64*((k < 52) ? k : 51) +: 64];
            bus.coef_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            fi = bus.in_valid && bus.in_ready;
            fp = bus.coef_valid && bus.coef_ready;
            if (bus.busy) busy_n++;
            if (bus.done) fin = 1;
            @(posedge clk); #1;
            if (fi) k++;
            if (fp) npop++;
            cyc++;
            if (abort_n >= 0 && npop == abort_n) begin
                bus.start = 0; bus.coef_ready = 0; bus.in_valid = 0;
                rst = 1;
                @(posedge clk); #1;
                chk("abort_in_ready",   64'(bus.in_ready),   64'd0);
                chk("abort_coef_valid", 64'(bus.coef_valid), 64'd0);
                chk("abort_busy",       64'(bus.busy),       64'd0);
                chk("abort_done",       64'(bus.done),       64'd0);
                chk("abort_coef_idx",   64'(bus.coef_idx),   64'd0);
                chk("abort_coef_out",   64'(bus.coef_out),   64'd0);
                rst = 0;
                fin = 1;
            end
        end
        bus.start = 0; bus.in_valid = 0; bus.coef_ready = 0;
        if (!fin) begin
            n_chk++;
            $display("FAIL timeout: got no done after %0d cycles want done", cyc);
        end
    endtask

    task automatic push_slices(input logic [3327:0] vec);
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.idx = i;
            e.val = vec[13*i +: 13];
            sb.push_back(e);
        end
    endtask

    task automatic settle_and_check(input string tag, input int busy_n, input int want_busy);
        repeat (2) @(negedge clk);
        if (want_busy >= 0) chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(want_busy));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(done_exp));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [3327:0] vec, inc_vec;
        exp_t e;
        int   busy_n;

        rst = 1; bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.coef_ready = 0;
        repeat (3) @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready",   64'(bus.in_ready),   64'd0);
        chk("rst_coef_valid", 64'(bus.coef_valid), 64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_done",       64'(bus.done),       64'd0);
        chk("rst_coef_idx",   64'(bus.coef_idx),   64'd0);
        chk("rst_coef_out",   64'(bus.coef_out),   64'd0);
`ifdef POLY_UNPACK_CHECK_EN
        chk("rst_err",        64'(bus.err),        64'd0);
`endif

        // incrementing coefficients, no stalls
        inc_vec = '0;
        for (int i = 0; i < 256; i++) inc_vec[13*i +: 13] = 13'(i);
        for (int i = 0; i < 256; i++) begin
            e.idx = i; e.val = 13'(i); sb.push_back(e);
        end
        run_poly(inc_vec, 100, -1, -1, busy_n);
        done_exp++;
        settle_and_check("t1", busy_n, 308);

        // random polynomial, 50% downstream stalls
        for (int w = 0; w < 52; w++) vec[64*w +: 64] = {$urandom, $urandom};
        push_slices(vec);
        run_poly(vec, 50, -1, -1, busy_n);
        done_exp++;
        settle_and_check("t2", busy_n, -1);

        // all-ones first word: carry of 12 ones into coefficient 4
        vec = '0;
        vec[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 256; i++) begin
            e.idx = i;
            e.val = (i < 4) ? 13'h1FFF : (i == 4) ? 13'h0FFF : 13'h0000;
            sb.push_back(e);
        end
        run_poly(vec, 100, -1, -1, busy_n);
        done_exp++;
        settle_and_check("t3", busy_n, 308);

        // reset after coefficient 100, then a clean full polynomial
        for (int w = 0; w < 52; w++) vec[64*w +: 64] = {$urandom, $urandom};
        push_slices(vec);
        run_poly(vec, 70, 101, -1, busy_n);
        sb.delete();
        settle_and_check("t4_abort", busy_n, -1);
        for (int i = 0; i < 256; i++) begin
            e.idx = i; e.val = 13'(i); sb.push_back(e);
        end
        run_poly(inc_vec, 100, -1, -1, busy_n);
        done_exp++;
        settle_and_check("t4_rerun", busy_n, 308);

        // start during RUN ignored; words after done not consumed
        for (int w = 0; w < 52; w++) vec[64*w +: 64] = {$urandom, $urandom};
        push_slices(vec);
        run_poly(vec, 100, -1, 40, busy_n);
        done_exp++;
        settle_and_check("t5", busy_n, 308);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.coef_ready = 1;
            @(negedge clk);
            chk("post_done_in_ready",   64'(bus.in_ready),   64'd0);
            chk("post_done_coef_valid", 64'(bus.coef_valid), 64'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 0; bus.coef_ready = 0;
        @(negedge clk);
        chk("post_done_no_second_done", 64'(done_cnt), 64'(done_exp));

`ifdef POLY_UNPACK_CHECK_EN
        begin
            int  guard;
            bit  found;
            @(posedge clk); #1;
            bus.start = 1; bus.in_valid = 1; bus.in_data = 64'hA5A5_0000_1234_5678;
            bus.coef_ready = 0;
            @(posedge clk); #1;
            bus.start = 0;
            found = 0;
            guard = 0;
            while (!found && guard < 20) begin
                @(negedge clk);
                if (bus.busy && !bus.in_ready) found = 1;
                @(posedge clk); #1;
                guard++;
            end
            if (!found) begin
                n_chk++;
                $display("FAIL err_setup: got in_ready never low want low within 20 cycles");
            end
            @(negedge clk);
            chk("err_before_change", 64'(bus.err), 64'd0);
            @(posedge clk); #1;
            bus.in_data = 64'h0BAD_0BAD_0BAD_0BAD;
            @(posedge clk); #1;
            @(negedge clk);
            chk("err_set", 64'(bus.err), 64'd1);
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("err_sticky", 64'(bus.err), 64'd1);
            @(posedge clk); #1;
            bus.start = 1;
            @(posedge clk); #1;
            bus.start = 0;
            @(negedge clk);
            chk("err_cleared_by_start", 64'(bus.err), 64'd0);
            @(posedge clk); #1;
            bus.in_valid = 0;
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
